// File: rtl/life_step_controller.sv
// Life step controller: paces Game-of-Life generations from a 1 s tick,
// launches datapath compute passes, commits them and counts generations.
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           asynchronous active-low reset
//   tick_in       one-cycle pulse from the 1-second timer
//   run           level, 1 = free-running generations, 0 = paused
//   step          one-cycle pulse, request one generation while paused
//   clear         one-cycle pulse, zero generation count / clear error
//   period_ticks  tick_in pulses per generation (0 treated as 1)
//   compute_done  one-cycle pulse from the cell-update datapath
//   compute_start one-cycle pulse launching a cell-update pass
//   commit        one-cycle pulse, datapath latches next board
//   busy          high while computing or committing
//   err           sticky, high in the error state
//   generation    count of committed generations
module life_step_controller #(
   parameter int PERIOD_W    = 8,
   parameter int GEN_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick_in,
   input  logic                run,
   input  logic                step,
   input  logic                clear,
   input  logic [PERIOD_W-1:0] period_ticks,
   input  logic                compute_done,
   output logic                compute_start,
   output logic                commit,
   output logic                busy,
   output logic                err,
   output logic [GEN_W-1:0]    generation
);

   localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_COMPUTE,
      ST_COMMIT,
      ST_ERROR
   } state_t;

   state_t              state;
   state_t              state_n;
   logic [PERIOD_W-1:0] tick_cnt;
   logic [PERIOD_W-1:0] tick_n;
   logic [TO_W-1:0]     to_cnt;
   logic [TO_W-1:0]     to_n;
   logic [GEN_W-1:0]    gen_n;
   logic [PERIOD_W-1:0] tick_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         tick_cnt   <= '0;
         to_cnt     <= '0;
         generation <= '0;
      end else begin
         state      <= state_n;
         tick_cnt   <= tick_n;
         to_cnt     <= to_n;
         generation <= gen_n;
      end
   end

   // A period of 0 behaves like 1, so the terminal count is 0 in both cases.
   always_comb begin
      tick_last = '0;
      if (period_ticks != '0) begin
         tick_last = period_ticks - PERIOD_W'(1);
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick_cnt;
      to_n    = to_cnt;
      gen_n   = generation;
      unique case (state)
         ST_IDLE: begin
            tick_n = '0;
            to_n   = '0;
            if (clear) begin
               gen_n = '0;
            end
            if (step) begin
               state_n = ST_COMPUTE;
            end else if (run) begin
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            to_n = '0;
            if (clear) begin
               gen_n = '0;
            end
            if (!run) begin
               state_n = ST_IDLE;
               tick_n  = '0;
            end else if (tick_in) begin
               // >= so a period shrunk below the count fires on the next tick
               if (tick_cnt >= tick_last) begin
                  state_n = ST_COMPUTE;
                  tick_n  = '0;
               end else begin
                  tick_n = tick_cnt + PERIOD_W'(1);
               end
            end
         end
         ST_COMPUTE: begin
            tick_n = '0;
            // done is not trusted in the launch cycle (to_cnt == 0)
            if (compute_done && (to_cnt != '0)) begin
               state_n = ST_COMMIT;
               to_n    = '0;
            end else if (to_cnt == TO_LAST) begin
               state_n = ST_ERROR;
               to_n    = '0;
            end else begin
               to_n = to_cnt + TO_W'(1);
            end
         end
         ST_COMMIT: begin
            tick_n  = '0;
            to_n    = '0;
            gen_n   = generation + GEN_W'(1);
            state_n = run ? ST_WAIT : ST_IDLE;
         end
         ST_ERROR: begin
            tick_n = '0;
            to_n   = '0;
            if (clear) begin
               state_n = ST_IDLE;
               gen_n   = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            tick_n  = '0;
            to_n    = '0;
         end
      endcase
   end

   // The pass counter only reads zero in the first COMPUTE cycle.
   assign compute_start = (state == ST_COMPUTE) && (to_cnt == '0);
   assign commit        = (state == ST_COMMIT);
   assign busy          = (state == ST_COMPUTE) || (state == ST_COMMIT);
   assign err           = (state == ST_ERROR);

endmodule

// File: tb/tb_life_step_controller.sv
// Scoreboard bench for life_step_controller: directed stimulus pushes
// expected start/commit/error events, a monitor pops and compares them.
module tb_life_step_controller;

   localparam int PW = 8;
   localparam int GW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick_in = 1'b0;
   logic          run = 1'b0;
   logic          step = 1'b0;
   logic          clear = 1'b0;
   logic [PW-1:0] period_ticks = 8'd3;
   logic          compute_done = 1'b0;
   logic          compute_start;
   logic          commit;
   logic          busy;
   logic          err;
   logic [GW-1:0] generation;

   life_step_controller #(
      .PERIOD_W(PW),
      .GEN_W(GW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick_in(tick_in),
      .run(run),
      .step(step),
      .clear(clear),
      .period_ticks(period_ticks),
      .compute_done(compute_done),
      .compute_start(compute_start),
      .commit(commit),
      .busy(busy),
      .err(err),
      .generation(generation)
   );

   always #5 clk = ~clk;

   typedef enum int {EV_START, EV_COMMIT, EV_ERR} ev_t;
   typedef struct {
      ev_t           kind;
      logic [GW-1:0] gen;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            failures = 0;
   logic [GW-1:0] exp_gen = '0;
   int            done_delay = 0;
   int            dcnt = 0;
   logic          err_q = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic sb_pop(input ev_t k);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s actual=%s required=none",
                  k.name(), k.name());
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.gen !== generation) begin
            failures++;
            $display("FAIL event actual=%s/gen%0d required=%s/gen%0d",
                     k.name(), generation, e.kind.name(), e.gen);
         end
      end
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         err_q = 1'b0;
      end else begin
         if (compute_start) sb_pop(EV_START);
         if (commit) sb_pop(EV_COMMIT);
         if (err && !err_q) sb_pop(EV_ERR);
         err_q = err;
      end
   end

   // Datapath model: done in COMPUTE cycle done_delay (0 = never).
   always @(negedge clk) begin
      if (!rst) begin
         dcnt = 0;
         compute_done = 1'b0;
      end else begin
         compute_done = 1'b0;
         if (compute_start) begin
            dcnt = done_delay;
         end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) compute_done = 1'b1;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_step;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   task automatic pulse_tick;
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
   endtask

   task automatic pulse_clear;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic exp_start;
      sb.push_back('{EV_START, exp_gen});
   endtask

   task automatic exp_commit;
      sb.push_back('{EV_COMMIT, exp_gen});
      exp_gen = exp_gen + 4'd1;
   endtask

   task automatic exp_err;
      sb.push_back('{EV_ERR, exp_gen});
   endtask

   initial begin
      #2 rst = 1'b0;
      cyc(2);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_gen", generation, 0);
      chk("rst_start", compute_start, 0);
      chk("rst_commit", commit, 0);
      rst = 1'b1;
      cyc(2);
      chk("idle_busy", busy, 0);

      // single step while paused; a second step during COMPUTE is ignored
      done_delay = 2;
      exp_start();
      exp_commit();
      pulse_step();
      chk("step_latency", compute_start, 1);
      pulse_step();
      cyc(4);
      chk("step_gen", generation, 1);
      chk("step_idle", busy, 0);

      // clear and step together: count zeroed and step honoured
      exp_gen = '0;
      exp_start();
      exp_commit();
      clear = 1'b1;
      step = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      step = 1'b0;
      cyc(5);
      chk("clrstep_gen", generation, 1);
      pulse_clear();
      cyc(1);
      chk("clear_gen", generation, 0);
      exp_gen = '0;

      // period 3, free running, done 5 cycles after start
      period_ticks = 8'd3;
      done_delay = 5;
      run = 1'b1;
      cyc(2);
      for (int g = 1; g <= 2; g++) begin
         exp_start();
         exp_commit();
         pulse_tick();
         cyc(1);
         chk("p3_t1_wait", busy, 0);
         pulse_tick();
         cyc(1);
         chk("p3_t2_wait", busy, 0);
         pulse_tick();
         chk("p3_t3_start", compute_start, 1);
         cyc(9);
         chk("p3_gen", generation, g);
      end

      // period shrinks below current count: next tick is terminal
      period_ticks = 8'd5;
      for (int i = 0; i < 3; i++) begin
         pulse_tick();
         cyc(1);
      end
      chk("p5_wait", busy, 0);
      period_ticks = 8'd2;
      cyc(1);
      exp_start();
      exp_commit();
      pulse_tick();
      chk("shrink_start", compute_start, 1);
      cyc(9);
      chk("shrink_gen", generation, 3);

      // period 0: every tick fires; a tick during COMPUTE is dropped
      period_ticks = 8'd0;
      exp_start();
      exp_commit();
      pulse_tick();
      chk("p0_start", compute_start, 1);
      pulse_tick();
      cyc(8);
      chk("p0_gen", generation, 4);
      chk("p0_wait", busy, 0);
      exp_start();
      exp_commit();
      pulse_tick();
      chk("p0_start2", compute_start, 1);
      cyc(9);
      chk("p0_gen2", generation, 5);

      // run drop beats a same-cycle terminal tick
      run = 1'b0;
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      chk("rundrop_start", compute_start, 0);
      cyc(2);
      chk("rundrop_busy", busy, 0);

      // step is ignored in WAIT
      run = 1'b1;
      cyc(1);
      pulse_step();
      chk("wait_step_start", compute_start, 0);
      run = 1'b0;
      cyc(2);

      // done on the last allowed COMPUTE cycle wins over timeout
      done_delay = TO - 1;
      exp_start();
      exp_commit();
      pulse_step();
      cyc(18);
      chk("edge_gen", generation, 6);
      chk("edge_err", err, 0);

      // timeout without done
      done_delay = 0;
      exp_start();
      exp_err();
      pulse_step();
      cyc(TO - 1);
      chk("to_pre_err", err, 0);
      chk("to_pre_busy", busy, 1);
      cyc(1);
      chk("to_err", err, 1);
      chk("to_busy", busy, 0);
      pulse_step();
      pulse_tick();
      run = 1'b1;
      cyc(2);
      chk("err_sticky", err, 1);
      run = 1'b0;
      pulse_clear();
      chk("errclr_err", err, 0);
      chk("errclr_gen", generation, 0);
      chk("errclr_busy", busy, 0);
      exp_gen = '0;

      // 16 steps: generation wraps 15 -> 0
      done_delay = 2;
      for (int i = 0; i < 16; i++) begin
         exp_start();
         exp_commit();
         pulse_step();
         cyc(4);
         if (i == 14) chk("wrap_15", generation, 15);
      end
      chk("wrap_0", generation, 0);

      // reset two cycles into COMPUTE abandons the pass
      done_delay = 5;
      exp_start();
      pulse_step();
      cyc(2);
      rst = 1'b0;
      #1;
      chk("mid_rst_start", compute_start, 0);
      chk("mid_rst_commit", commit, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_gen", generation, 0);
      cyc(2);
      rst = 1'b1;
      cyc(8);
      chk("post_rst_gen", generation, 0);
      chk("post_rst_busy", busy, 0);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/life_step_controller.md
LIFE_STEP_CONTROLLER -- requirements
Module: life_step_controller

Interface
REQ-001 Parameter: PERIOD_W, default 8, width of the ticks-per-generation setting.
REQ-002 Parameter: GEN_W, default 16, width of the generation counter.
REQ-003 Parameter: TIMEOUT_CYC, default 1024, max clk cycles allowed in COMPUTE before error.
REQ-004 Port: clk  input  1  system clock (12 MHz board clock); all state updates on posedge clk.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 Port: tick_in  input  1  one-cycle pulse from the 1-second timer.
REQ-007 Port: run  input  1  level; 1 = free-running generations, 0 = paused.
REQ-008 Port: step  input  1  one-cycle pulse; request exactly one generation while paused.
REQ-009 Port: clear  input  1  one-cycle pulse; zero generation count and clear error.
REQ-010 Port: period_ticks  input  PERIOD_W  tick_in pulses per generation; value 0 treated as 1.
REQ-011 Port: compute_done  input  1  one-cycle pulse from the cell-update datapath.
REQ-012 Port: compute_start  output  1  one-cycle pulse launching a cell-update pass.
REQ-013 Port: commit  output  1  one-cycle pulse; datapath latches next board into current board.
REQ-014 Port: busy  output  1  high while state is COMPUTE or COMMIT.
REQ-015 Port: err  output  1  sticky; high in ERROR state.
REQ-016 Port: generation  output  GEN_W  count of committed generations.

Function
REQ-017 States SHALL be IDLE, WAIT, COMPUTE, COMMIT, ERROR; all outputs registered or decoded from registered state.
REQ-018 IDLE: step=1 -> COMPUTE (step has priority over run); else run=1 -> WAIT; else stay.
REQ-019 IDLE: clear=1 SHALL zero generation; clear and step same cycle -> generation zeroed and step honoured.
REQ-020 WAIT: tick counter SHALL be 0 on entry and increment on each tick_in.
REQ-021 WAIT: tick_in with counter == max(period_ticks,1)-1 -> COMPUTE; counter returns to 0.
REQ-022 WAIT: run=0 -> IDLE (takes priority over a same-cycle terminal tick); step ignored in WAIT.
REQ-023 period_ticks SHALL be sampled every cycle; decrease below current count -> terminal on next tick_in.
REQ-024 compute_start SHALL be 1 exactly in the first cycle state is COMPUTE, 0 otherwise.
REQ-025 COMPUTE: compute_done SHALL be ignored in the compute_start cycle; sampled from second COMPUTE cycle on.
REQ-026 COMPUTE: compute_done=1 -> COMMIT; tick_in, step, run, clear ignored in COMPUTE and COMMIT.
REQ-027 COMPUTE: cycle counter from 0 on entry; reaching TIMEOUT_CYC-1 without done -> ERROR, err=1; done same cycle wins.
REQ-028 COMMIT: lasts exactly one cycle with commit=1; generation increments by 1, wrapping all-ones -> 0.
REQ-029 COMMIT exit: run=1 -> WAIT (tick counter 0), else IDLE.
REQ-030 ERROR: compute_start, commit 0; clear=1 -> IDLE, err=0, generation=0; other inputs ignored.
REQ-031 Latency: step pulse in IDLE -> compute_start next cycle; done -> commit next cycle.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, tick and timeout counters 0, generation 0, err 0, compute_start 0, commit 0, busy 0.
REQ-033 Reset mid-COMPUTE SHALL abandon the pass with no commit and no generation increment.
REQ-034 After rst rises, first state change SHALL occur no earlier than the following posedge clk.

Verification
REQ-035 period_ticks=3, run=1, done 5 cycles after each start: compute_start after every 3rd tick_in; generation 0->1->2.
REQ-036 run=0, step pulse: compute_start next cycle, done 2 cycles later, commit 1 cycle, generation=1, back to IDLE; step during COMPUTE ignored.
REQ-037 period_ticks=0, run=1: every tick_in triggers a generation; tick_in during COMPUTE not counted.
REQ-038 TIMEOUT_CYC=16, no compute_done: err=1 after 16 COMPUTE cycles; clear -> IDLE, err=0, generation=0.
REQ-039 GEN_W=4, 16 steps from 0: generation wraps 15 -> 0 on 16th commit.
REQ-040 rst=0 two cycles after compute_start: all outputs 0 immediately, no commit, generation unchanged at 0.
